// File: rtl/elevator_pkg.sv
// Shared elevator constants: floor count, floor index width, direction codes
// and the dispatcher state type.
package elevator_pkg;

  localparam int FLOORS = 5;
  localparam int LOC_W  = 3;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  // State codes equal the direction codes so the direction output is the state itself.
  typedef enum logic [1:0] {
    ST_IDLE = DIR_IDLE,
    ST_UP   = DIR_UP,
    ST_DOWN = DIR_DOWN
  } state_t;

endpackage

// File: rtl/call_dispatcher_if.sv
// Call and car-feedback bundle between the button/car side and the dispatcher.
interface call_dispatcher_if #(
  parameter int FLOORS = elevator_pkg::FLOORS,
  parameter int LOC_W  = elevator_pkg::LOC_W
);
  logic [FLOORS-1:0] btn_outer;
  logic [FLOORS-1:0] btn_inner;
  logic [LOC_W-1:0]  car_location;
  logic              car_arrived;
  logic [LOC_W-1:0]  dest;
  logic              dest_valid;
  logic [1:0]        direction;
  logic [FLOORS-1:0] pending;

  modport master (
    output btn_outer, btn_inner, car_location, car_arrived,
    input  dest, dest_valid, direction, pending
  );

  modport slave (
    input  btn_outer, btn_inner, car_location, car_arrived,
    output dest, dest_valid, direction, pending
  );
endinterface

// File: rtl/call_dispatcher_call_register.sv
// Per-floor call latch: set by a press, cleared by arrival, clear wins a tie.
module call_register #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         enable,
  input  logic [W-1:0] set_req,
  input  logic [W-1:0] clr_req,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (resetn)
      q <= '0;
    else if (enable)
      q <= (q | set_req) & ~clr_req;
  end

endmodule

// File: rtl/call_dispatcher.sv
// Collective-control call dispatcher: latches floor calls and picks the next
// destination, keeping direction while calls remain ahead of the car.
module call_dispatcher #(
  parameter int FLOORS = elevator_pkg::FLOORS,
  parameter int LOC_W  = elevator_pkg::LOC_W
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            enable,
  call_dispatcher_if.slave bus
);
  import elevator_pkg::*;

  logic [FLOORS-1:0] set_req, clr_req, pending_q;
  logic              loc_valid, any_above, any_below;
  logic [LOC_W-1:0]  above_idx, below_idx, dist_up, dist_dn;
  state_t            state, nxt_state;
  logic [LOC_W-1:0]  dest_q, nxt_dest;
  logic              valid_q, nxt_valid;

  assign loc_valid = {1'b0, bus.car_location} < (LOC_W+1)'(FLOORS);
  assign set_req   = bus.btn_outer | bus.btn_inner;

  // An out-of-range location never matches a floor index, so it clears nothing.
  always_comb begin
    for (int k = 0; k < FLOORS; k++)
      clr_req[k] = bus.car_arrived && (bus.car_location == LOC_W'(k));
  end

  call_register #(.W(FLOORS)) u_calls (
    .clk     (clk),
    .resetn  (resetn),
    .enable  (enable),
    .set_req (set_req),
    .clr_req (clr_req),
    .q       (pending_q)
  );

  // Descending scan leaves the lowest call above; ascending leaves the highest below.
  // NOTE: every combinational output gets a default first, so no latch is inferred.
  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    above_idx = '0;
    below_idx = '0;
    for (int k = FLOORS-1; k >= 0; k--) begin
      if (pending_q[k] && (LOC_W'(k) > bus.car_location)) begin
        any_above = 1'b1;
        above_idx = LOC_W'(k);
      end
    end
    for (int k = 0; k < FLOORS; k++) begin
      if (pending_q[k] && (LOC_W'(k) < bus.car_location)) begin
        any_below = 1'b1;
        below_idx = LOC_W'(k);
      end
    end
  end

  assign dist_up = above_idx - bus.car_location;
  assign dist_dn = bus.car_location - below_idx;

  always_comb begin
    nxt_state = state;
    nxt_dest  = dest_q;
    nxt_valid = 1'b0;
    if (loc_valid && (pending_q != '0)) begin
      nxt_valid = 1'b1;
      unique case (state)
        ST_UP:   nxt_state = any_above ? ST_UP : (any_below ? ST_DOWN : ST_IDLE);
        ST_DOWN: nxt_state = any_below ? ST_DOWN : (any_above ? ST_UP : ST_IDLE);
        default: begin
          if (any_above && any_below)
            nxt_state = (dist_up <= dist_dn) ? ST_UP : ST_DOWN;
          else if (any_above)
            nxt_state = ST_UP;
          else if (any_below)
            nxt_state = ST_DOWN;
          else
            nxt_state = ST_IDLE;
        end
      endcase
      unique case (nxt_state)
        ST_UP:   nxt_dest = above_idx;
        ST_DOWN: nxt_dest = below_idx;
        default: nxt_dest = bus.car_location;
      endcase
    end else if (loc_valid) begin
      nxt_state = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state   <= ST_IDLE;
      dest_q  <= '0;
      valid_q <= 1'b0;
    end else if (enable) begin
      state   <= nxt_state;
      dest_q  <= nxt_dest;
      valid_q <= nxt_valid;
    end
  end

  assign bus.pending    = pending_q;
  assign bus.direction  = state;
  assign bus.dest       = dest_q;
  assign bus.dest_valid = valid_q;

endmodule

// File: tb/tb_call_dispatcher.sv
// Self-checking bench for call_dispatcher: directed vector table, enable/reset
// sequence, then randomized traffic against a floor-list reference model.
module tb_call_dispatcher;
  import elevator_pkg::*;

  logic clk = 1'b0;
  logic resetn, enable;
  int   vectors = 0;
  int   miscompares = 0;

  call_dispatcher_if bus ();

  call_dispatcher dut (
    .clk    (clk),
    .resetn (resetn),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] bo;
    logic [4:0] bi;
    logic [2:0] loc;
    logic       arr;
    logic [4:0] p;
    logic [1:0] dir;
    logic [2:0] dest;
    logic       v;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(logic [4:0] bo, logic [4:0] bi, logic [2:0] loc, logic arr,
                              logic [4:0] p, logic [1:0] dir, logic [2:0] dest, logic v);
    vec_t r;
    r.bo = bo; r.bi = bi; r.loc = loc; r.arr = arr;
    r.p = p; r.dir = dir; r.dest = dest; r.v = v;
    return r;
  endfunction

  task automatic check(input string name, input logic [4:0] p, input logic [1:0] dir,
                       input logic [2:0] dest, input logic v);
    vectors++;
    if ({bus.pending, bus.direction, bus.dest, bus.dest_valid} !== {p, dir, dest, v}) begin
      miscompares++;
      $display("FAIL %s: got pending=%b dir=%b dest=%0d valid=%b, expected pending=%b dir=%b dest=%0d valid=%b",
               name, bus.pending, bus.direction, bus.dest, bus.dest_valid, p, dir, dest, v);
    end
  endtask

  task automatic drive(input logic [4:0] bo, input logic [4:0] bi, input logic [2:0] loc, input logic arr);
    bus.btn_outer    = bo;
    bus.btn_inner    = bi;
    bus.car_location = loc;
    bus.car_arrived  = arr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: calls kept as a floor set, decisions from nearest-call distances.
  bit   [4:0] m_pend;
  logic [1:0] m_dir;
  int         m_dest;
  bit         m_valid;

  task automatic model_reset();
    m_pend = '0; m_dir = DIR_IDLE; m_dest = 0; m_valid = 1'b0;
  endtask

  task automatic model_step(input bit rst, input bit en, input logic [4:0] bo, input logic [4:0] bi,
                            input int l, input bit arr);
    int up_f, dn_f;
    logic [1:0] nd;
    if (rst) begin
      model_reset();
      return;
    end
    if (!en) return;
    if (l < FLOORS) begin
      up_f = -1; dn_f = -1;
      for (int f = 0; f < FLOORS; f++) begin
        if (m_pend[f] && f > l && (up_f < 0 || f < up_f)) up_f = f;
        if (m_pend[f] && f < l && f > dn_f) dn_f = f;
      end
      if (m_pend == 0) begin
        m_dir = DIR_IDLE; m_valid = 1'b0;
      end else begin
        m_valid = 1'b1;
        if (m_dir == DIR_UP)
          nd = (up_f >= 0) ? DIR_UP : (dn_f >= 0) ? DIR_DOWN : DIR_IDLE;
        else if (m_dir == DIR_DOWN)
          nd = (dn_f >= 0) ? DIR_DOWN : (up_f >= 0) ? DIR_UP : DIR_IDLE;
        else if (up_f >= 0 && dn_f >= 0)
          nd = ((up_f - l) <= (l - dn_f)) ? DIR_UP : DIR_DOWN;
        else
          nd = (up_f >= 0) ? DIR_UP : (dn_f >= 0) ? DIR_DOWN : DIR_IDLE;
        m_dir  = nd;
        m_dest = (nd == DIR_UP) ? up_f : (nd == DIR_DOWN) ? dn_f : l;
      end
    end else begin
      m_valid = 1'b0;
    end
    for (int f = 0; f < FLOORS; f++) begin
      if (arr && l == f) m_pend[f] = 1'b0;
      else if (bo[f] || bi[f]) m_pend[f] = 1'b1;
    end
  endtask

  initial begin
    tbl[0]  = mk(5'h08, 5'h00, 3'd0, 1'b0, 5'h08, DIR_IDLE, 3'd0, 1'b0);
    tbl[1]  = mk(5'h00, 5'h00, 3'd0, 1'b0, 5'h08, DIR_UP,   3'd3, 1'b1);
    tbl[2]  = mk(5'h00, 5'h00, 3'd3, 1'b1, 5'h00, DIR_IDLE, 3'd3, 1'b1);
    tbl[3]  = mk(5'h00, 5'h00, 3'd3, 1'b0, 5'h00, DIR_IDLE, 3'd3, 1'b0);
    tbl[4]  = mk(5'h00, 5'h10, 3'd1, 1'b0, 5'h10, DIR_IDLE, 3'd3, 1'b0);
    tbl[5]  = mk(5'h00, 5'h00, 3'd1, 1'b0, 5'h10, DIR_UP,   3'd4, 1'b1);
    tbl[6]  = mk(5'h00, 5'h04, 3'd1, 1'b0, 5'h14, DIR_UP,   3'd4, 1'b1);
    tbl[7]  = mk(5'h00, 5'h00, 3'd1, 1'b0, 5'h14, DIR_UP,   3'd2, 1'b1);
    tbl[8]  = mk(5'h00, 5'h00, 3'd2, 1'b1, 5'h10, DIR_UP,   3'd4, 1'b1);
    tbl[9]  = mk(5'h00, 5'h00, 3'd2, 1'b0, 5'h10, DIR_UP,   3'd4, 1'b1);
    tbl[10] = mk(5'h00, 5'h00, 3'd4, 1'b1, 5'h00, DIR_IDLE, 3'd4, 1'b1);
    tbl[11] = mk(5'h00, 5'h00, 3'd4, 1'b0, 5'h00, DIR_IDLE, 3'd4, 1'b0);
    tbl[12] = mk(5'h11, 5'h00, 3'd2, 1'b0, 5'h11, DIR_IDLE, 3'd4, 1'b0);
    tbl[13] = mk(5'h00, 5'h00, 3'd2, 1'b0, 5'h11, DIR_UP,   3'd4, 1'b1);
    tbl[14] = mk(5'h00, 5'h00, 3'd4, 1'b1, 5'h01, DIR_DOWN, 3'd0, 1'b1);
    tbl[15] = mk(5'h00, 5'h00, 3'd4, 1'b0, 5'h01, DIR_DOWN, 3'd0, 1'b1);
    tbl[16] = mk(5'h00, 5'h00, 3'd0, 1'b1, 5'h00, DIR_IDLE, 3'd0, 1'b1);
    tbl[17] = mk(5'h00, 5'h00, 3'd0, 1'b0, 5'h00, DIR_IDLE, 3'd0, 1'b0);
    tbl[18] = mk(5'h08, 5'h00, 3'd3, 1'b1, 5'h00, DIR_IDLE, 3'd0, 1'b0);
    tbl[19] = mk(5'h00, 5'h00, 3'd3, 1'b0, 5'h00, DIR_IDLE, 3'd0, 1'b0);
    tbl[20] = mk(5'h00, 5'h04, 3'd0, 1'b0, 5'h04, DIR_IDLE, 3'd0, 1'b0);
    tbl[21] = mk(5'h00, 5'h00, 3'd0, 1'b0, 5'h04, DIR_UP,   3'd2, 1'b1);
    tbl[22] = mk(5'h00, 5'h00, 3'd6, 1'b1, 5'h04, DIR_UP,   3'd2, 1'b0);
    tbl[23] = mk(5'h00, 5'h00, 3'd6, 1'b0, 5'h04, DIR_UP,   3'd2, 1'b0);
    tbl[24] = mk(5'h00, 5'h00, 3'd2, 1'b1, 5'h00, DIR_IDLE, 3'd2, 1'b1);
    tbl[25] = mk(5'h00, 5'h00, 3'd2, 1'b0, 5'h00, DIR_IDLE, 3'd2, 1'b0);

    enable = 1'b1;
    resetn = 1'b1;
    drive(5'h00, 5'h00, 3'd0, 1'b0);
    step();
    step();
    resetn = 1'b0;
    check("reset", 5'h00, DIR_IDLE, 3'd0, 1'b0);

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].bo, tbl[i].bi, tbl[i].loc, tbl[i].arr);
      step();
      check($sformatf("table[%0d]", i), tbl[i].p, tbl[i].dir, tbl[i].dest, tbl[i].v);
    end

    // Enable low freezes everything and swallows presses; reset drops travel.
    drive(5'h10, 5'h00, 3'd0, 1'b0); step();
    check("en_setup_latch", 5'h10, DIR_IDLE, 3'd2, 1'b0);
    drive(5'h00, 5'h00, 3'd0, 1'b0); step();
    check("en_setup_up", 5'h10, DIR_UP, 3'd4, 1'b1);
    enable = 1'b0;
    drive(5'h00, 5'h02, 3'd4, 1'b1); step();
    check("enable_low_hold", 5'h10, DIR_UP, 3'd4, 1'b1);
    enable = 1'b1;
    drive(5'h00, 5'h00, 3'd0, 1'b0); step();
    check("enable_resume", 5'h10, DIR_UP, 3'd4, 1'b1);
    resetn = 1'b1; step();
    resetn = 1'b0;
    check("reset_mid_travel", 5'h00, DIR_IDLE, 3'd0, 1'b0);

    model_reset();
    begin
      logic [4:0] bo, bi;
      logic [2:0] loc;
      logic arr, rst, en;
      loc = 3'd0;
      for (int c = 0; c < 3000; c++) begin
        bo  = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31)) : 5'h00;
        bi  = ($urandom_range(0, 5) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'h00;
        if ($urandom_range(0, 3) == 0)
          loc = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        arr = ($urandom_range(0, 3) == 0);
        en  = ($urandom_range(0, 9) != 0);
        rst = ($urandom_range(0, 299) == 0);
        drive(bo, bi, loc, arr);
        enable = en;
        resetn = rst;
        model_step(rst, en, bo, bi, int'(loc), arr);
        step();
        check($sformatf("random[%0d]", c), m_pend, m_dir, 3'(m_dest), m_valid);
      end
      resetn = 1'b0;
      enable = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/call_dispatcher.md
# call_dispatcher

Collects hall (outer) and car (inner) floor calls for the 5-floor elevator and decides which floor the car serves next. It drives the destination side of the car interface, `dest`/`dest_valid`, into `car_indicator`. It consumes `car_location` and an arrival pulse back from the car. It sits between the debounced `pushbutton` outputs and `car_indicator` in `main_module`. Scheduling is collective: the car keeps its direction until no calls remain ahead of it.

## Interface
- `FLOORS`, default 5: number of floors, indices 0..FLOORS-1.
- `LOC_W`, default 3: width of floor index.
- `clk`: input, 1 bit. System clock; all state updates on its rising edge.
- `resetn`: input, 1 bit. Reset, synchronous, active-high.
- `enable`: input, 1 bit. When 0, every register holds its value.
- `btn_outer`: input, FLOORS bits. Hall-call pulses, one cycle per press, bit k = floor k.
- `btn_inner`: input, FLOORS bits. Car-call pulses, same encoding as `btn_outer`.
- `car_location`: input, LOC_W bits. Current car floor from `car_indicator`.
- `car_arrived`: input, 1 bit. One-cycle pulse: car stopped at `car_location` and the door cycle completed.
- `dest`: output, LOC_W bits. Target floor for the car.
- `dest_valid`: output, 1 bit. `dest` holds a pending call.
- `direction`: output, 2 bits. Encoded as IDLE=00, UP=01, DOWN=10.
- `pending`: output, FLOORS bits. Latched calls; drives the call lamps.

## Operation
- **Call latch:**
  - `pending[k]` is set by `btn_outer[k] | btn_inner[k]`.
  - `pending[k]` is cleared when `car_arrived` is high and `car_location == k`.
  - If set and clear hit the same floor in the same cycle, clear wins (the door is already servicing that floor).
- **States:** IDLE, UP, DOWN; `direction` mirrors the state.
- **Definitions:** A = any pending floor above `car_location`; B = any pending floor below it; H = pending at `car_location`.
- **IDLE:**
  - If A and B both hold, go to the nearer side; on equal distance go to UP.
  - If only A holds, go to UP. If only B holds, go to DOWN.
  - If only H holds, stay IDLE with `dest = car_location`, `dest_valid = 1`.
- **UP:**
  - `dest` = lowest pending floor above `car_location`.
  - If no floor above is pending: go to DOWN if B holds, else IDLE.
- **DOWN:** symmetric to UP. `dest` = highest pending floor below `car_location`. If none: go to UP if A holds, else IDLE.
- **dest_valid:** 1 when `pending != 0` and `car_location` is valid; otherwise 0 and `dest` holds its last value.
- **Invalid location** (`car_location >= FLOORS`): no clear, state holds, `dest_valid` = 0.
- **Enable low:** presses arriving while `enable = 0` are discarded, not deferred.
- **Reset values:** `pending` = 0, state IDLE, `direction` = 00, `dest` = 0, `dest_valid` = 0. Reset mid-travel drops all calls.

## Timing
- A press at cycle n sets `pending` at n+1.
- The state, `dest` and `dest_valid` reflect that call at n+2; they are registered from the registered `pending`.
- `car_arrived` at cycle n clears the bit at n+1. The new `dest` or direction change appears at n+2.
- `dest` changes only on a cycle edge. It may retarget mid-travel to a nearer same-direction call (collective pickup).
- No combinational path from the inputs to any output.

## Structure
- Shared package `elevator_pkg`:
  - `FLOORS`, `LOC_W`;
  - direction encodings `DIR_IDLE`/`DIR_UP`/`DIR_DOWN`;
  - state typedef.
  - `car_indicator` and `main_module` import the same constants.
- Sub-module `call_register`: per-floor set/clear latch with clear priority and enable hold, instantiated once, FLOORS wide.
- Top-level logic: above/below masks, priority encoders for nearest-above and nearest-below, FSM, output registers.

## Test plan
1. Reset, then idle car at 0. Pulse `btn_outer[3]` -> `pending` = 01000 at n+1; `direction` = UP, `dest` = 3, `dest_valid` = 1 at n+2.
2. Car at 1 going UP to 4. Pulse `btn_inner[2]` -> `dest` = 2 two cycles later. `car_arrived` at location 2 -> `pending[2]` cleared, `dest` = 4.
3. Car at 2, IDLE. Presses at floors 0 and 4 in the same cycle -> equal distance, so `direction` = UP, `dest` = 4. After arrival at 4 -> DOWN, `dest` = 0.
4. `car_arrived` at location 3 in the same cycle as `btn_outer[3]` -> `pending[3]` = 0. With no other calls -> IDLE, `dest_valid` = 0.
5. `enable` = 0 during a press at floor 1 -> `pending` unchanged. Raise `enable` -> state resumes unchanged. `resetn` = 1 mid-travel -> all outputs at reset values the next cycle.
6. `car_location` = 6 with `pending` = 00100 -> `dest_valid` = 0, no clear on `car_arrived`, state held.
